// File: rtl/kseq_pkg.sv
// Shared types and constants for the kernel-word sequencer.
package kseq_pkg;

  typedef enum logic [1:0] {
    KSEQ_ONESHOT     = 2'b00,
    KSEQ_LOOP        = 2'b01,
    KSEQ_ONESHOT_SR2 = 2'b10,
    KSEQ_LOOP_SR2    = 2'b11
  } kseq_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } kseq_state_e;

  localparam logic [2:0] SHIFTRIGHT2 = 3'b001;

endpackage

// File: rtl/kseq_mem.sv
// DEPTH x WIDTH register file: async reset to zero, one write port,
// one combinational read port.
module kseq_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Decoded loops keep out-of-range addresses harmless for non-power-of-two DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (raddr == AW'(i)) rdata = mem[i];
  end

endmodule

// File: rtl/kernel_sequencer.sv
// Loads kernel words into a register file, then replays them over a
// valid/ready stream in one-shot or loop mode, optionally shifted right by 2.
module kernel_sequencer
  import kseq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW:0]      cfg_len,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ptr
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  kseq_state_e      state, state_d;
  kseq_mode_e       mode_q, mode_d;
  logic [AW:0]      len_q, len_d, len_clamp;
  logic [AW-1:0]    ptr_d;
  logic             done_d;
  logic             mem_we;
  logic             last;
  logic             shift;
  logic [WIDTH-1:0] rdata;

  kseq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (ptr),
    .rdata (rdata)
  );

  assign len_clamp = (cfg_len == '0 || cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign last      = ({1'b0, ptr} == len_q - 1'b1);
  assign shift     = (mode_q == KSEQ_ONESHOT_SR2) || (mode_q == KSEQ_LOOP_SR2);

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign out_data  = (state != RUN) ? '0 :
                     shift ? {2'b00, rdata[WIDTH-1:2]} : rdata;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    len_d   = len_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        mem_we = wr_en && ({1'b0, wr_addr} < DEPTH_L);
        if (start && !stop) begin
          state_d = RUN;
          ptr_d   = '0;
          len_d   = len_clamp;
          mode_d  = kseq_mode_e'(mode);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else if (out_ready) begin
          if (!last) begin
            ptr_d = ptr + 1'b1;
          end else if (mode_q == KSEQ_LOOP || mode_q == KSEQ_LOOP_SR2) begin
            ptr_d = '0;
          end else begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      len_q  <= '0;
      mode_q <= KSEQ_ONESHOT;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      len_q  <= len_d;
      mode_q <= mode_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_kernel_sequencer.sv
// Randomized and directed bench for kernel_sequencer against a word-level replay model.
module tb_kernel_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [AW:0]      cfg_len = '0;
  logic [1:0]       mode = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid, busy, done;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    ptr;

  kernel_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cfg_len   (cfg_len),
    .mode      (mode),
    .start     (start),
    .stop      (stop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  logic [7:0] acc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Word-level model: which entry is on offer, how many remain, what mode.
  logic [7:0] mm [DEPTH];
  bit m_run, m_loop, m_shift, m_done;
  int m_idx, m_len;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (mm[i]) mm[i] = 8'h00;
      m_run = 0; m_loop = 0; m_shift = 0; m_done = 0; m_idx = 0; m_len = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (wr_en && int'(wr_addr) < DEPTH) mm[wr_addr] = wr_data;
        if (start && !stop) begin
          m_run = 1;
          m_idx = 0;
          m_len = (cfg_len == 0 || int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
          m_loop = mode[0];
          m_shift = mode[1];
        end
      end else if (stop) begin
        m_run = 0;
        m_idx = 0;
      end else if (out_ready) begin
        if (m_idx + 1 < m_len) m_idx++;
        else begin
          m_idx = 0;
          if (!m_loop) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] ed;
    ed = m_run ? (m_shift ? (mm[m_idx] >> 2) : mm[m_idx]) : 8'h00;
    chk("out_valid", out_valid, m_run);
    chk("busy", busy, m_run);
    chk("done", done, m_done);
    chk("ptr", ptr, m_idx);
    chk("out_data", out_data, ed);
    if (done) n_done++;
    if (rst_n && out_valid && out_ready) acc.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load5();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_addr = AW'(i);
      wr_data = 8'((i + 1) * 17);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic launch(input logic [1:0] m, input logic [AW:0] l);
    mode = m;
    cfg_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int cycles);
    int k;
    cycles = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    chk({nm, "_done_seen"}, k < 60, 1);
  endtask

  task automatic wait_ptr(input string nm, input int p);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid && int'(ptr) == p) break;
    end
    chk({nm, "_ptr_reached"}, k < 60, 1);
  endtask

  task automatic check_acc(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_count"}, acc.size() >= exp.size(), 1);
    for (int i = 0; i < exp.size() && i < acc.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), acc[i], exp[i]);
  endtask

  initial begin
    int cyc, d0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_data", out_data, 0);

    // One-shot full length: five consecutive words, done six cycles after start.
    load5();
    out_ready = 1'b1;
    acc.delete();
    d0 = n_done;
    launch(2'b00, 4'd0);
    wait_done("oneshot", cyc);
    chk("oneshot_latency", cyc, 6);
    chk("oneshot_busy_at_done", busy, 0);
    check_acc("oneshot", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    tick();
    chk("oneshot_done_pulses", n_done - d0, 1);

    // Loop length 3 with a toggling consumer.
    acc.delete();
    d0 = n_done;
    out_ready = 1'b0;
    launch(2'b01, 4'd3);
    for (int i = 0; i < 12; i++) begin
      out_ready = ~out_ready;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    out_ready = 1'b1;
    check_acc("loop3", '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22});
    chk("loop3_no_done", n_done - d0, 0);

    // Shifted single word.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    acc.delete();
    launch(2'b10, 4'd1);
    wait_done("sr2", cyc);
    chk("sr2_latency", cyc, 2);
    check_acc("sr2", '{8'h3F});

    // Stop at ptr 2 with simultaneous start and write; out-of-range write after.
    load5();
    launch(2'b01, 4'd0);
    wait_ptr("stop", 1);
    tick();
    stop = 1'b1; start = 1'b1; mode = 2'b00;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
    tick();
    stop = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    acc.delete();
    launch(2'b00, 4'd7);
    wait_done("after_stop", cyc);
    check_acc("after_stop", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

    // Start issued in the done cycle.
    tick();
    acc.delete();
    launch(2'b00, 4'd2);
    wait_ptr("chain", 1);
    tick();
    chk("chain_done_cycle", done, 1);
    launch(2'b11, 4'd3);
    for (int k = 0; k < 20 && acc.size() < 6; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_acc("chain", '{8'h11, 8'h22, 8'h04, 8'h08, 8'h0C, 8'h04});

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      cfg_len = 4'($urandom_range(0, 15));
      mode = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    out_ready = 1'b1;

    // Reset mid-replay.
    load5();
    launch(2'b00, 4'd0);
    wait_ptr("rst", 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ptr", ptr, 0);
    chk("midrst_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    acc.delete();
    launch(2'b00, 4'd0);
    wait_done("post_rst", cyc);
    check_acc("post_rst_zero", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    tick();
    load5();
    acc.delete();
    launch(2'b00, 4'd0);
    wait_done("reload", cyc);
    check_acc("reload", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
